// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: width, op encodings,
// controller states and the architecturally defined special results.
package div_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } div_state_t;

    localparam logic [XLEN-1:0] DIV_ZERO_QUO = '1;
    localparam logic [XLEN-1:0] INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    // funct3[0] clear selects the signed variants, funct3[1] set selects remainder.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up in a final cycle, single-cycle register-file writeback.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int CNT_W = $clog2(XLEN);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [4:0]       rd_q;
    logic             is_rem_q, neg_quo_q, neg_rem_q;

    logic signed [XLEN-1:0] dvd_s, dvs_s;
    logic             sgn_op, dvd_neg, dvs_neg, div_zero, ovf, special;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    shifted, diff;
    logic             take;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign dvd_s    = $signed(rs1_data);
    assign dvs_s    = $signed(rs2_data);
    assign sgn_op   = op_is_signed(op);
    assign dvd_neg  = sgn_op && (dvd_s < 0);
    assign dvs_neg  = sgn_op && (dvs_s < 0);
    assign div_zero = (rs2_data == '0);
    assign ovf      = sgn_op && (rs1_data == INT_MIN) && (rs2_data == DIV_ZERO_QUO);
    assign special  = div_zero || ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op_is_rem(op) ? rs1_data : DIV_ZERO_QUO;
        else
            special_res = op_is_rem(op) ? '0 : INT_MIN;
    end

    // Trial subtraction on XLEN+1 bits; a clear top bit means the divisor fits.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[XLEN];

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = special ? ST_DONE : ST_CALC;
                ST_CALC:  if (cnt == CNT_W'(XLEN-1)) state_next = ST_FINAL;
                ST_FINAL: state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else if (!flush) begin
            case (state)
                // Accept: operands enter as magnitudes, signs kept for the fix-up.
                ST_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        rem_q     <= '0;
                        quo_q     <= cond_neg(rs1_data, dvd_neg);
                        dvs_q     <= cond_neg(rs2_data, dvs_neg);
                        rd_q      <= rd_addr;
                        is_rem_q  <= op_is_rem(op);
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        if (special) begin
                            wb_data <= special_res;
                            wb_addr <= rd_addr;
                        end
                    end
                end
                // Iterate: quotient bits shift in from the right as dividend bits leave.
                ST_CALC: begin
                    rem_q <= take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], take};
                    cnt   <= cnt + CNT_W'(1);
                end
                // Sign correction and result select.
                ST_FINAL: begin
                    wb_data <= is_rem_q ? cond_neg(rem_q, neg_rem_q)
                                        : cond_neg(quo_q, neg_quo_q);
                    wb_addr <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != ST_IDLE);
    assign wb_en = (state == ST_DONE) && (rd_q != 5'd0);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected writebacks are queued at issue and
// matched against each wb_en pulse, including the edge at which it appears.
module tb_div_unit;
    import div_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [4:0]      rd_addr = '0;
    logic            flush = 1'b0;
    logic            busy, wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   wb_cnt = 0;

    div_unit dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb_;
        sa  = a;
        sb_ = b;
        case (o)
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b11: return (b == 0) ? a : a % b;
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb_);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb_);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Writeback monitor: every wb_en cycle must consume exactly one expectation.
    always @(negedge clk) begin
        if (wb_en) begin
            wb_cnt++;
            if (sb.size() == 0) begin
                check("wb_unexpected", {27'd0, wb_addr}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                check("wb_data", wb_data, e.data);
                check("wb_latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input bit want_wb);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
        if (want_wb && rd != 5'd0) begin
            exp_t e;
            e.addr = rd;
            e.data = exp;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) check(tag, 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        launch(o, a, b, rd, exp, lat, 1'b1);
        wait_idle("idle_timeout");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_before, n_busy;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [4:0]  rd;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
        do_op(OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 34);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 34);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 34);
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 34);
        do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 34);
        do_op(OP_DIV, 32'h1234_5678, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
        do_op(OP_REM, 32'h1234_5678, 32'd0, 5'd7, 32'h1234_5678, 1);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1);

        // A second start while busy must not disturb the latched operands.
        launch(OP_DIVU, 32'd100, 32'd7, 5'd6, 32'd14, 34, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; op = OP_REMU; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("ignored_start_timeout");

        // Flush mid-calculation: no writeback, then a fresh op at the next edge.
        wb_before = wb_cnt;
        launch(OP_DIVU, 32'd999, 32'd10, 5'd10, 32'd0, 0, 1'b0);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_wb_en", {31'd0, wb_en}, 32'd0);
        do_op(OP_DIVU, 32'd1000, 32'd3, 5'd11, 32'd333, 34);
        check("flush_no_wb", 32'(wb_cnt - wb_before), 32'd1);

        // Flush wins over start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1_data = 32'd5; rs2_data = 32'd1; rd_addr = 5'd12;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset mid-calculation discards the op and clears the write port.
        wb_before = wb_cnt;
        launch(OP_DIVU, 32'd12345, 32'd17, 5'd13, 32'd0, 0, 1'b0);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_wb_en", {31'd0, wb_en}, 32'd0);
        check("rstmid_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_wb", 32'(wb_cnt - wb_before), 32'd0);

        // rd=0: full-length busy, no write enable.
        wb_before = wb_cnt;
        launch(OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 34, 1'b1);
        n_busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            else break;
        end
        check("rd0_busy_cycles", 32'(n_busy), 32'd34);
        check("rd0_no_wb", 32'(wb_cnt - wb_before), 32'd0);

        do_op(OP_DIVU, 32'd0, 32'd9, 5'd14, 32'd0, 34);
        do_op(OP_REM, 32'hFFFF_FF00, 32'd1, 5'd15, 32'd0, 34);
        do_op(OP_REMU, 32'd5, 32'd9, 5'd16, 32'd5, 34);

        for (int i = 0; i < 1800; i++) begin
            o  = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(1, 31));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'($urandom_range(0, 255));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = a + 32'($urandom_range(1, 1000));
                4: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            do_op(o, a, b, rd, ref_div(o, a, b), ref_lat(o, a, b));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
